// File: rtl/cix32_pipe_ctrl_pkg.sv
// cix32_defines: shared pipe-control state type, stage indices and stall-point helper.
package cix32_defines;

    typedef enum logic [1:0] {
        PS_RUN      = 2'd0,
        PS_REDIRECT = 2'd1,
        PS_DRAIN    = 2'd2
    } pipe_state_t;

    // Stage indices, oldest stage has the largest index
    localparam logic [2:0] STG_F    = 3'd0;
    localparam logic [2:0] STG_D    = 3'd1;
    localparam logic [2:0] STG_E    = 3'd2;
    localparam logic [2:0] STG_M    = 3'd3;
    localparam logic [2:0] STG_W    = 3'd4;
    localparam logic [2:0] STG_NONE = 3'd7;

    // Oldest stalled stage wins; STG_NONE when nothing is stalled.
    function automatic logic [2:0] stall_point(
        input logic stall_f,
        input logic stall_d,
        input logic stall_e,
        input logic stall_m
    );
        logic [2:0] s;
        s = STG_NONE;
        if (stall_m) begin
            s = STG_M;
        end else if (stall_e) begin
            s = STG_E;
        end else if (stall_d) begin
            s = STG_D;
        end else if (stall_f) begin
            s = STG_F;
        end
        return s;
    endfunction

endpackage

// File: rtl/cix32_sat_counter.sv
// cix32_sat_counter: event counter that sticks at all-ones instead of wrapping.
module cix32_sat_counter
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count: advance on inc unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cix32_pipe_ctrl.sv
// cix32_pipe_ctrl: turns hazard-unit stall/flush requests into per-stage register
// enables and valid bits for the F/D/E/M/W pipe, and runs the fetch redirect handshake.
module cix32_pipe_ctrl
    import cix32_defines::*;
#(
    parameter int unsigned PC_WIDTH      = 32,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned FLUSH_BUBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_fetch_i,
    input  logic                 stall_decode_i,
    input  logic                 stall_execute_i,
    input  logic                 stall_memory_i,
    input  logic                 flush_i,
    input  logic [PC_WIDTH-1:0]  redirect_pc_i,
    input  logic                 fetch_valid_i,
    input  logic                 redirect_ready_i,
    output logic                 en_fd_o,
    output logic                 en_de_o,
    output logic                 en_em_o,
    output logic                 en_mw_o,
    output logic                 valid_d_o,
    output logic                 valid_e_o,
    output logic                 valid_m_o,
    output logic                 valid_w_o,
    output logic                 redirect_valid_o,
    output logic [PC_WIDTH-1:0]  redirect_pc_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam logic [3:0] BUBBLE_LOAD = 4'(FLUSH_BUBBLES);

    pipe_state_t         state_q;
    pipe_state_t         state_d;
    logic [3:0]          bubble_q;
    logic [3:0]          bubble_d;
    logic [PC_WIDTH-1:0] redirect_pc_q;
    logic [PC_WIDTH-1:0] redirect_pc_d;

    logic valid_d_q;
    logic valid_d_d;
    logic valid_e_q;
    logic valid_e_d;
    logic valid_m_q;
    logic valid_m_d;
    logic valid_w_q;
    logic valid_w_d;

    logic [2:0] stall_pt;
    logic       any_stall;
    logic       fetch_ok;

    assign any_stall = stall_fetch_i | stall_decode_i | stall_execute_i | stall_memory_i;
    assign fetch_ok  = (state_q == PS_RUN);

    // Stall point and register enables. A fetch stall holds F/D just like a decode
    // stall. A flush overrides D/E stalls so the younger stages load bubbles, but an
    // M stall still freezes everything up to E/M. Enables are forced high in reset.
    always_comb begin
        stall_pt = stall_point(stall_fetch_i, stall_decode_i, stall_execute_i, stall_memory_i);
        if (flush_i) begin
            stall_pt = stall_memory_i ? STG_M : STG_NONE;
        end
        en_fd_o = 1'b1;
        en_de_o = 1'b1;
        en_em_o = 1'b1;
        en_mw_o = 1'b1;
        if (!rst) begin
            case (stall_pt)
                STG_M: begin
                    en_fd_o = 1'b0;
                    en_de_o = 1'b0;
                    en_em_o = 1'b0;
                end
                STG_E: begin
                    en_fd_o = 1'b0;
                    en_de_o = 1'b0;
                end
                STG_D, STG_F: begin
                    en_fd_o = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next valid bits: held stages keep theirs, the stage just past the stall point
    // takes a bubble, older stages advance; a flush kills whatever is in D and E.
    always_comb begin
        valid_d_d = valid_d_q;
        valid_e_d = valid_e_q;
        valid_m_d = valid_m_q;
        valid_w_d = valid_w_q;
        case (stall_pt)
            STG_M: begin
                valid_w_d = 1'b0;
            end
            STG_E: begin
                valid_m_d = 1'b0;
                valid_w_d = valid_m_q;
            end
            STG_D, STG_F: begin
                valid_e_d = 1'b0;
                valid_m_d = valid_e_q;
                valid_w_d = valid_m_q;
            end
            default: begin
                valid_d_d = fetch_valid_i & fetch_ok;
                valid_e_d = valid_d_q;
                valid_m_d = valid_e_q;
                valid_w_d = valid_m_q;
            end
        endcase
        if (flush_i) begin
            valid_d_d = 1'b0;
            valid_e_d = 1'b0;
        end
    end

    // Redirect FSM: a flush always (re)enters REDIRECT and captures the target; the
    // accepted redirect is followed by FLUSH_BUBBLES cycles of squashed fetch.
    always_comb begin
        state_d       = state_q;
        bubble_d      = bubble_q;
        redirect_pc_d = redirect_pc_q;
        if (flush_i) begin
            state_d       = PS_REDIRECT;
            redirect_pc_d = redirect_pc_i;
        end else begin
            case (state_q)
                PS_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_d  = PS_DRAIN;
                        bubble_d = BUBBLE_LOAD;
                    end
                end
                PS_DRAIN: begin
                    if (bubble_q <= 4'd1) begin
                        state_d = PS_RUN;
                    end else begin
                        bubble_d = bubble_q - 4'd1;
                    end
                end
                default: begin
                    state_d = PS_RUN;
                end
            endcase
        end
    end

    // FSM state, bubble counter and redirect target registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= PS_RUN;
            bubble_q      <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            bubble_q      <= bubble_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Per-stage valid bit registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d_q <= 1'b0;
            valid_e_q <= 1'b0;
            valid_m_q <= 1'b0;
            valid_w_q <= 1'b0;
        end else begin
            valid_d_q <= valid_d_d;
            valid_e_q <= valid_e_d;
            valid_m_q <= valid_m_d;
            valid_w_q <= valid_w_d;
        end
    end

    cix32_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .clr     (rst),
        .inc     (any_stall),
        .count_o (stall_cnt_o)
    );

    cix32_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk     (clk),
        .clr     (rst),
        .inc     (flush_i),
        .count_o (flush_cnt_o)
    );

    assign valid_d_o        = valid_d_q;
    assign valid_e_o        = valid_e_q;
    assign valid_m_o        = valid_m_q;
    assign valid_w_o        = valid_w_q;
    assign redirect_valid_o = (state_q == PS_REDIRECT);
    assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_cix32_pipe_ctrl.sv
// tb_cix32_pipe_ctrl: directed scenarios plus a randomized run, all checked against a
// stage-array reference model of the pipe controller.
module tb_cix32_pipe_ctrl;

    localparam int PCW  = 32;
    localparam int CW   = 8;
    localparam int FB   = 2;
    localparam int CMAX = (1 << CW) - 1;

    localparam int M_RUN      = 0;
    localparam int M_REDIRECT = 1;
    localparam int M_DRAIN    = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall_fetch_i;
    logic            stall_decode_i;
    logic            stall_execute_i;
    logic            stall_memory_i;
    logic            flush_i;
    logic [PCW-1:0]  redirect_pc_i;
    logic            fetch_valid_i;
    logic            redirect_ready_i;
    logic            en_fd_o;
    logic            en_de_o;
    logic            en_em_o;
    logic            en_mw_o;
    logic            valid_d_o;
    logic            valid_e_o;
    logic            valid_m_o;
    logic            valid_w_o;
    logic            redirect_valid_o;
    logic [PCW-1:0]  redirect_pc_o;
    logic [CW-1:0]   stall_cnt_o;
    logic [CW-1:0]   flush_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: valid bit per stage (1=D .. 4=W), redirect mode, counters
    bit [1:4]       m_valid;
    int             m_mode;
    int             m_drain;
    logic [PCW-1:0] m_pc;
    int             m_scnt;
    int             m_fcnt;

    logic [8:0] dut_flags;
    assign dut_flags = {en_fd_o, en_de_o, en_em_o, en_mw_o,
                        valid_d_o, valid_e_o, valid_m_o, valid_w_o, redirect_valid_o};

    cix32_pipe_ctrl #(
        .PC_WIDTH      (PCW),
        .CNT_WIDTH     (CW),
        .FLUSH_BUBBLES (FB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_fetch_i    (stall_fetch_i),
        .stall_decode_i   (stall_decode_i),
        .stall_execute_i  (stall_execute_i),
        .stall_memory_i   (stall_memory_i),
        .flush_i          (flush_i),
        .redirect_pc_i    (redirect_pc_i),
        .fetch_valid_i    (fetch_valid_i),
        .redirect_ready_i (redirect_ready_i),
        .en_fd_o          (en_fd_o),
        .en_de_o          (en_de_o),
        .en_em_o          (en_em_o),
        .en_mw_o          (en_mw_o),
        .valid_d_o        (valid_d_o),
        .valid_e_o        (valid_e_o),
        .valid_m_o        (valid_m_o),
        .valid_w_o        (valid_w_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    always #5 clk = ~clk;

    // Index of the oldest stage that must hold (0 = none, 1 = D, 2 = E, 3 = M)
    function automatic int model_hold();
        if (flush_i) return stall_memory_i ? 3 : 0;
        if (stall_memory_i) return 3;
        if (stall_execute_i) return 2;
        if (stall_decode_i || stall_fetch_i) return 1;
        return 0;
    endfunction

    // Expected enables/valids/redirect_valid for the current inputs and model state
    function automatic logic [8:0] model_flags();
        logic [1:4] en;
        int hs;
        hs = model_hold();
        for (int k = 1; k <= 4; k++) en[k] = rst ? 1'b1 : (k > hs);
        return {en[1], en[2], en[3], en[4],
                m_valid[1], m_valid[2], m_valid[3], m_valid[4], (m_mode == M_REDIRECT)};
    endfunction

    // Advance the model by one clock using the current inputs
    task automatic model_step();
        bit [1:4] nv;
        int hs;
        if (rst) begin
            m_valid = '0;
            m_mode  = M_RUN;
            m_drain = 0;
            m_pc    = '0;
            m_scnt  = 0;
            m_fcnt  = 0;
            return;
        end
        hs = model_hold();
        for (int k = 1; k <= 4; k++) begin
            if (k <= hs) nv[k] = m_valid[k];
            else if (hs > 0 && k == hs + 1) nv[k] = 1'b0;
            else if (k == 1) nv[k] = fetch_valid_i && (m_mode == M_RUN);
            else nv[k] = m_valid[k-1];
        end
        if (flush_i) begin
            nv[1] = 1'b0;
            nv[2] = 1'b0;
        end
        if (stall_fetch_i || stall_decode_i || stall_execute_i || stall_memory_i)
            m_scnt = (m_scnt >= CMAX) ? CMAX : m_scnt + 1;
        if (flush_i) m_fcnt = (m_fcnt >= CMAX) ? CMAX : m_fcnt + 1;
        if (flush_i) begin
            m_mode = M_REDIRECT;
            m_pc   = redirect_pc_i;
        end else if (m_mode == M_REDIRECT) begin
            if (redirect_ready_i) begin
                m_mode  = M_DRAIN;
                m_drain = FB;
            end
        end else if (m_mode == M_DRAIN) begin
            m_drain = m_drain - 1;
            if (m_drain == 0) m_mode = M_RUN;
        end
        m_valid = nv;
    endtask

    // Apply one set of inputs just after the falling edge; st = {M, E, D, F}
    task automatic drive(input bit r, input bit [3:0] st, input bit fl,
                         input logic [PCW-1:0] pc, input bit fv, input bit rr);
        rst              = r;
        stall_memory_i   = st[3];
        stall_execute_i  = st[2];
        stall_decode_i   = st[1];
        stall_fetch_i    = st[0];
        flush_i          = fl;
        redirect_pc_i    = pc;
        fetch_valid_i    = fv;
        redirect_ready_i = rr;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        drive(1'b1, 4'b1111, 1'b0, 32'hdead_beef, 1'b1, 1'b1);
        checks++;
        if (dut_flags[8:5] !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL reset_enables got=%b exp=1111", dut_flags[8:5]);
        end
        tick();
        tick();
        drive(1'b0, 4'b0000, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (dut_flags !== 9'b1111_0000_0) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b exp=111100000", dut_flags);
        end
        checks++;
        if (redirect_pc_o !== '0 || stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_regs pc=%h scnt=%0d fcnt=%0d exp all 0",
                     redirect_pc_o, stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_fill();
        logic expw;
        $display("[TB] test_fill");
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 4'b0000, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (dut_flags !== model_flags()) begin
                errors++;
                $display("[TB] FAIL fill_flags cyc=%0d got=%b exp=%b", i, dut_flags, model_flags());
            end
            tick();
            if (i == 3 || i == 4) begin
                expw = (i == 4);
                checks++;
                if (valid_w_o !== expw) begin
                    errors++;
                    $display("[TB] FAIL fill_valid_w cyc=%0d got=%b exp=%b", i, valid_w_o, expw);
                end
            end
        end
    endtask

    task automatic test_stall_execute();
        $display("[TB] test_stall_execute");
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 4'b0100, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (dut_flags[8:5] !== 4'b0011) begin
                errors++;
                $display("[TB] FAIL stallE_enables cyc=%0d got=%b exp=0011", i, dut_flags[8:5]);
            end
            tick();
            checks++;
            if ({valid_d_o, valid_e_o, valid_m_o} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL stallE_valids cyc=%0d got=%b exp=110", i,
                         {valid_d_o, valid_e_o, valid_m_o});
            end
        end
        checks++;
        if (stall_cnt_o !== CW'(3)) begin
            errors++;
            $display("[TB] FAIL stallE_count got=%0d exp=3", stall_cnt_o);
        end
    endtask

    task automatic test_flush();
        $display("[TB] test_flush");
        drive(1'b0, 4'b0000, 1'b1, 32'h0000_1000, 1'b1, 1'b0);
        checks++;
        if (dut_flags !== model_flags()) begin
            errors++;
            $display("[TB] FAIL flush_flags got=%b exp=%b", dut_flags, model_flags());
        end
        tick();
        checks++;
        if ({valid_d_o, valid_e_o} !== 2'b00 || flush_cnt_o !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL flush_kill de=%b fcnt=%0d exp de=00 fcnt=1",
                     {valid_d_o, valid_e_o}, flush_cnt_o);
        end
        for (int i = 1; i <= 2; i++) begin
            drive(1'b0, 4'b0000, 1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h0000_1000) begin
                errors++;
                $display("[TB] FAIL flush_redirect_hold cyc=%0d rv=%b pc=%h exp rv=1 pc=00001000",
                         i, redirect_valid_o, redirect_pc_o);
            end
            tick();
        end
    endtask

    task automatic test_drain();
        logic expd;
        $display("[TB] test_drain");
        drive(1'b0, 4'b0000, 1'b0, 32'hffff_ffff, 1'b1, 1'b1);
        checks++;
        if (redirect_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_handshake rv=%b exp=1", redirect_valid_o);
        end
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 4'b0000, 1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
            expd = (i == 4);
            checks++;
            if (valid_d_o !== expd || (i == 1 && redirect_valid_o !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL drain_seq cyc=%0d vd=%b rv=%b exp vd=%b", i, valid_d_o,
                         redirect_valid_o, expd);
            end
            tick();
        end
    endtask

    task automatic test_reflush();
        $display("[TB] test_reflush");
        drive(1'b0, 4'b0000, 1'b1, 32'h0000_1000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'b0000, 1'b1, 32'h0000_2000, 1'b1, 1'b1);
        checks++;
        if (redirect_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reflush_in_redirect rv=%b exp=1", redirect_valid_o);
        end
        tick();
        checks++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h0000_2000 || flush_cnt_o !== CW'(3)) begin
            errors++;
            $display("[TB] FAIL reflush_pc rv=%b pc=%h fcnt=%0d exp rv=1 pc=00002000 fcnt=3",
                     redirect_valid_o, redirect_pc_o, flush_cnt_o);
        end
        drive(1'b0, 4'b0010, 1'b1, 32'h0000_2000, 1'b1, 1'b0);
        checks++;
        if ({en_fd_o, en_de_o} !== 2'b11 || dut_flags !== model_flags()) begin
            errors++;
            $display("[TB] FAIL flush_beats_stallD got=%b exp=%b", dut_flags, model_flags());
        end
        tick();
        checks++;
        if ({valid_d_o, valid_e_o} !== 2'b00 || flush_cnt_o !== CW'(4)) begin
            errors++;
            $display("[TB] FAIL flush_beats_stallD_after de=%b fcnt=%0d exp de=00 fcnt=4",
                     {valid_d_o, valid_e_o}, flush_cnt_o);
        end
        drive(1'b0, 4'b0000, 1'b0, '0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_reset_in_drain();
        $display("[TB] test_reset_in_drain");
        drive(1'b1, 4'b1000, 1'b1, 32'h5555_5555, 1'b1, 1'b1);
        checks++;
        if (dut_flags[8:5] !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL rst_drain_enables got=%b exp=1111", dut_flags[8:5]);
        end
        tick();
        drive(1'b0, 4'b0000, 1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (dut_flags !== 9'b1111_0000_0 || stall_cnt_o !== '0 || flush_cnt_o !== '0 ||
            redirect_pc_o !== '0) begin
            errors++;
            $display("[TB] FAIL rst_drain_state flags=%b scnt=%0d fcnt=%0d pc=%h exp 111100000/0/0/0",
                     dut_flags, stall_cnt_o, flush_cnt_o, redirect_pc_o);
        end
        for (int i = 1; i <= CMAX - 1; i++) begin
            drive(1'b0, 4'($urandom_range(1, 15)), 1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (dut_flags !== model_flags()) begin
                errors++;
                $display("[TB] FAIL sat_flags cyc=%0d got=%b exp=%b", i, dut_flags, model_flags());
            end
            tick();
        end
        checks++;
        if (stall_cnt_o !== CW'(CMAX - 1)) begin
            errors++;
            $display("[TB] FAIL sat_pre got=%0d exp=%0d", stall_cnt_o, CMAX - 1);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 4'($urandom_range(1, 15)), 1'b0, '0, 1'b1, 1'b0);
            tick();
            checks++;
            if (stall_cnt_o !== CW'(CMAX)) begin
                errors++;
                $display("[TB] FAIL sat_hold cyc=%0d got=%0d exp=%0d", i, stall_cnt_o, CMAX);
            end
        end
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) == 0), 4'($urandom & $urandom),
                  ($urandom_range(0, 7) == 0), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (dut_flags !== model_flags()) begin
                errors++;
                $display("[TB] FAIL rand_flags cyc=%0d got=%b exp=%b", i, dut_flags, model_flags());
            end
            checks++;
            if (redirect_pc_o !== m_pc) begin
                errors++;
                $display("[TB] FAIL rand_pc cyc=%0d got=%h exp=%h", i, redirect_pc_o, m_pc);
            end
            checks++;
            if (stall_cnt_o !== CW'(m_scnt) || flush_cnt_o !== CW'(m_fcnt)) begin
                errors++;
                $display("[TB] FAIL rand_counters cyc=%0d scnt=%0d fcnt=%0d exp %0d/%0d",
                         i, stall_cnt_o, flush_cnt_o, m_scnt, m_fcnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall_execute();
        test_flush();
        test_drain();
        test_reflush();
        test_reset_in_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
